obstacle_tile_renderer: RTL and testbench

Pipelined, parametrised successor to the obstacle pixel colouriser. It maps the per-pixel ROM coordinate of an obstacle block to a 12-bit RGB value and selects among STYLE_NUM wall styles. It adds a run-time writable palette, a frame-tick-driven style animation phase, and a valid-qualified 3-cycle pipeline. It sits between the obstacle hit/position logic and the VGA pixel mux.

---
 rtl/obstacle_render_pkg.sv | 40 ++++
 rtl/obstacle_style_rom.sv | 34 +++
 rtl/obstacle_tile_renderer.sv | 143 ++++++++++++++
 tb/tb_obstacle_tile_renderer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/obstacle_render_pkg.sv
// Shared constants for the obstacle tile renderer: widths, default palette,
// hash/offset constants and the per-style wall bitmaps.
package obstacle_render_pkg;

  localparam int STYLE_WIDTH_DEF = 2;
  localparam int COLOR_WIDTH_DEF = 2;
  localparam int HASH_CHUNK      = 3;
  localparam int RND_OFFSET      = 7;

  localparam logic [11:0] PAL_DEF_0 = 12'h5B0;
  localparam logic [11:0] PAL_DEF_1 = 12'h000;
  localparam logic [11:0] PAL_DEF_2 = 12'h777;
  localparam logic [11:0] PAL_DEF_3 = 12'hAAA;

  function automatic logic [11:0] pal_default(input int idx);
    case (idx)
      0:       return PAL_DEF_0;
      1:       return PAL_DEF_1;
      2:       return PAL_DEF_2;
      3:       return PAL_DEF_3;
      default: return 12'h000;
    endcase
  endfunction

  // Styles 0..3 are border, stripes, checker and diagonal; styles 4..7 reuse
  // them with the colour index mirrored so every style stays distinct.
  function automatic int style_pixel(input int style, input int v, input int u);
    int pat;
    pat = 0;
    case (style % 4)
      0:       pat = (u == 0 || v == 0) ? 1 : 2;
      1:       pat = ((v % 2) == 1) ? 3 : 2;
      2:       pat = (((u ^ v) & 1) == 1) ? 3 : 0;
      default: pat = (u + v) % 4;
    endcase
    if (style >= 4) pat = 3 - pat;
    return pat;
  endfunction

endpackage

// File: rtl/obstacle_style_rom.sv
// Style bitmap ROM with a registered read; rows at or beyond the tile height
// of the bitmap read back as colour index 0.
module obstacle_style_rom
  import obstacle_render_pkg::*;
#(
  parameter int OBSTACLE_WIDTH = 10,
  parameter int SCREEN_WIDTH   = 10,
  parameter int STYLE_WIDTH    = STYLE_WIDTH_DEF,
  parameter int COLOR_WIDTH    = COLOR_WIDTH_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [STYLE_WIDTH-1:0]  style_i,
  input  logic [SCREEN_WIDTH-1:0] v_i,
  input  logic [SCREEN_WIDTH-1:0] u_i,
  output logic [COLOR_WIDTH-1:0]  idx_o
);

  logic [COLOR_WIDTH-1:0] idx_q;

  // Address {style, v, u} flattened as style*W*W + v*W + u.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else if (int'(v_i) < OBSTACLE_WIDTH) begin
      idx_q <= COLOR_WIDTH'(style_pixel(int'(style_i), int'(v_i), int'(u_i)));
    end else begin
      idx_q <= '0;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/obstacle_tile_renderer.sv
// Three-stage obstacle tile renderer: style/coordinate select, style ROM read,
// palette lookup, with a writable palette and frame-driven style animation.
module obstacle_tile_renderer
  import obstacle_render_pkg::*;
#(
  parameter int OBSTACLE_WIDTH = 10,
  parameter int SCREEN_WIDTH   = 10,
  parameter int PHY_WIDTH      = 16,
  parameter int PIXEL_WIDTH    = 12,
  parameter int STYLE_NUM      = 4,
  parameter int STYLE_WIDTH    = STYLE_WIDTH_DEF,
  parameter int COLOR_NUM      = 4,
  parameter int COLOR_WIDTH    = COLOR_WIDTH_DEF
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic                    pix_valid,
  input  logic [SCREEN_WIDTH-1:0] obstacle_x_rom,
  input  logic [SCREEN_WIDTH-1:0] obstacle_y_rom,
  input  logic [PHY_WIDTH-1:0]    obstacle_block_abs_y,
  input  logic [PHY_WIDTH-1:0]    obstacle_abs_pos_y,
  input  logic [PHY_WIDTH-1:0]    obstacle_abs_pos_x,
  input  logic                    obstacle_on,
  input  logic                    anim_en,
  input  logic                    frame_tick,
  input  logic                    pal_wr_en,
  input  logic [COLOR_WIDTH-1:0]  pal_wr_idx,
  input  logic [PIXEL_WIDTH-1:0]  pal_wr_data,
  output logic [PIXEL_WIDTH-1:0]  rgb,
  output logic                    rgb_on,
  output logic                    rgb_valid
);

  localparam int HASH_BITS = ((PHY_WIDTH + HASH_CHUNK - 1) / HASH_CHUNK) * HASH_CHUNK;

  logic [STYLE_WIDTH-1:0]  phase_q;
  logic [STYLE_WIDTH-1:0]  style_d, s1Style_q;
  logic [SCREEN_WIDTH-1:0] u_d, v_d, s1U_q, s1V_q;
  logic                    s1On_q, s1Valid_q, s2On_q, s2Valid_q;
  logic [COLOR_WIDTH-1:0]  s2Idx;
  logic [PIXEL_WIDTH-1:0]  rgb_q;
  logic                    rgbOn_q, rgbValid_q;
  logic [PIXEL_WIDTH-1:0]  pal_q [COLOR_NUM];

  logic [SCREEN_WIDTH-1:0] which, xMod;
  logic [PHY_WIDTH-1:0]    blockX;
  logic [HASH_BITS-1:0]    posYPad;
  logic [HASH_CHUNK-1:0]   hash;
  logic [STYLE_WIDTH-1:0]  base, phaseEff;
  logic                    rnd, face;

  assign posYPad = HASH_BITS'(obstacle_abs_pos_y);

  // Stage-1 select: pick a style from the block position or the y hash,
  // then mirror the column when the tile faces the other way.
  always_comb begin
    which  = obstacle_x_rom / SCREEN_WIDTH'(OBSTACLE_WIDTH);
    xMod   = obstacle_x_rom % SCREEN_WIDTH'(OBSTACLE_WIDTH);
    blockX = (obstacle_abs_pos_x << 1) + obstacle_block_abs_y
           + PHY_WIDTH'(OBSTACLE_WIDTH) * PHY_WIDTH'(which) - PHY_WIDTH'(RND_OFFSET);
    hash   = '0;
    for (int i = 0; i < HASH_BITS / HASH_CHUNK; i++) begin
      hash = hash ^ posYPad[i*HASH_CHUNK +: HASH_CHUNK];
    end
    rnd      = blockX[4] & blockX[3] & (|blockX[1:0]);
    base     = rnd ? STYLE_WIDTH'(blockX) : STYLE_WIDTH'(hash);
    phaseEff = anim_en ? phase_q : '0;
    style_d  = STYLE_WIDTH'((int'(base) + int'(phaseEff)) % STYLE_NUM);
    face     = rnd | (hash[1] ^ hash[0]);
    u_d      = face ? xMod : SCREEN_WIDTH'(OBSTACLE_WIDTH - 1) - xMod;
    v_d      = obstacle_y_rom >> 1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      phase_q <= '0;
    end else if (anim_en && frame_tick) begin
      phase_q <= (phase_q == STYLE_WIDTH'(STYLE_NUM - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1Style_q <= '0;
      s1U_q     <= '0;
      s1V_q     <= '0;
      s1On_q    <= 1'b0;
      s1Valid_q <= 1'b0;
      s2On_q    <= 1'b0;
      s2Valid_q <= 1'b0;
    end else begin
      s1Style_q <= style_d;
      s1U_q     <= u_d;
      s1V_q     <= v_d;
      s1On_q    <= obstacle_on;
      s1Valid_q <= pix_valid;
      s2On_q    <= s1On_q;
      s2Valid_q <= s1Valid_q;
    end
  end

  obstacle_style_rom #(
    .OBSTACLE_WIDTH(OBSTACLE_WIDTH),
    .SCREEN_WIDTH  (SCREEN_WIDTH),
    .STYLE_WIDTH   (STYLE_WIDTH),
    .COLOR_WIDTH   (COLOR_WIDTH)
  ) u_rom (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .style_i(s1Style_q),
    .v_i    (s1V_q),
    .u_i    (s1U_q),
    .idx_o  (s2Idx)
  );

  // Write and stage-3 read share an edge, so a colliding read sees the old entry.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < COLOR_NUM; i++) begin
        pal_q[i] <= PIXEL_WIDTH'(pal_default(i));
      end
    end else if (pal_wr_en) begin
      pal_q[pal_wr_idx] <= pal_wr_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb_q      <= '0;
      rgbOn_q    <= 1'b0;
      rgbValid_q <= 1'b0;
    end else begin
      rgb_q      <= s2On_q ? pal_q[s2Idx] : '0;
      rgbOn_q    <= s2On_q;
      rgbValid_q <= s2Valid_q;
    end
  end

  assign rgb       = rgb_q;
  assign rgb_on    = rgbOn_q;
  assign rgb_valid = rgbValid_q;

endmodule

// File: tb/tb_obstacle_tile_renderer.sv
// Scoreboard bench for obstacle_tile_renderer: directed pixels push expected
// colours, an independent monitor pops them whenever rgb_valid is high.
module tb_obstacle_tile_renderer;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  obstacle_x_rom = '0;
  logic [9:0]  obstacle_y_rom = '0;
  logic [15:0] obstacle_block_abs_y = '0;
  logic [15:0] obstacle_abs_pos_y = '0;
  logic [15:0] obstacle_abs_pos_x = '0;
  logic        obstacle_on = 1'b0;
  logic        anim_en = 1'b0;
  logic        frame_tick = 1'b0;
  logic        pal_wr_en = 1'b0;
  logic [1:0]  pal_wr_idx = '0;
  logic [11:0] pal_wr_data = '0;
  logic [11:0] rgb;
  logic        rgb_on;
  logic        rgb_valid;

  always #5 sys_clk = ~sys_clk;

  obstacle_tile_renderer dut (
    .sys_clk             (sys_clk),
    .sys_rst_n           (sys_rst_n),
    .pix_valid           (pix_valid),
    .obstacle_x_rom      (obstacle_x_rom),
    .obstacle_y_rom      (obstacle_y_rom),
    .obstacle_block_abs_y(obstacle_block_abs_y),
    .obstacle_abs_pos_y  (obstacle_abs_pos_y),
    .obstacle_abs_pos_x  (obstacle_abs_pos_x),
    .obstacle_on         (obstacle_on),
    .anim_en             (anim_en),
    .frame_tick          (frame_tick),
    .pal_wr_en           (pal_wr_en),
    .pal_wr_idx          (pal_wr_idx),
    .pal_wr_data         (pal_wr_data),
    .rgb                 (rgb),
    .rgb_on              (rgb_on),
    .rgb_valid           (rgb_valid)
  );

  typedef struct {
    logic [11:0] rgb;
    logic        on;
    int          cyc;
    int          id;
  } exp_t;

  exp_t expQ[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cycleCount = 0;

  always @(posedge sys_clk) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input int id, input int actual, input int required);
    compared++;
    if (actual != required) begin
      mismatched++;
      $display("[TB] FAIL %s pixel %0d: got 0x%0h, expected 0x%0h", name, id, actual, required);
    end
  endtask

  // Drives one pixel for one cycle; the expected output is due 3 edges later.
  task automatic applyStimulus(input int id, input logic [15:0] ax, input logic [15:0] by,
                               input logic [15:0] ay, input logic [9:0] xr, input logic [9:0] yr,
                               input logic on, input logic valid, input logic [11:0] expRgb,
                               input logic push);
    exp_t e;
    obstacle_abs_pos_x   = ax;
    obstacle_block_abs_y = by;
    obstacle_abs_pos_y   = ay;
    obstacle_x_rom       = xr;
    obstacle_y_rom       = yr;
    obstacle_on          = on;
    pix_valid            = valid;
    if (valid && push) begin
      e.rgb = on ? expRgb : 12'h000;
      e.on  = on;
      e.cyc = cycleCount + 3;
      e.id  = id;
      expQ.push_back(e);
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  always @(negedge sys_clk) begin : monitor
    exp_t e;
    if (sys_rst_n && rgb_valid) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_valid: got rgb_valid=1 rgb=0x%0h, expected rgb_valid=0", rgb);
      end else begin
        e = expQ.pop_front();
        checkOutput("rgb", e.id, int'(rgb), int'(e.rgb));
        checkOutput("rgb_on", e.id, int'(rgb_on), int'(e.on));
        checkOutput("latency", e.id, cycleCount, e.cyc);
      end
    end
  end

  initial begin
    repeat (3) @(posedge sys_clk);
    #1;
    checkOutput("reset_rgb", 0, int'(rgb), 0);
    checkOutput("reset_rgb_on", 0, int'(rgb_on), 0);
    checkOutput("reset_rgb_valid", 0, int'(rgb_valid), 0);
    sys_rst_n = 1'b1;
    idle(2);

    // Back-to-back directed pixels covering style select, hash, face and v limits.
    applyStimulus(1,  16'd0, 16'd0, 16'h0000, 10'd0,    10'd0,  1'b1, 1'b1, 12'h777, 1'b1);
    applyStimulus(2,  16'd4, 16'd0, 16'h0005, 10'd3,    10'd2,  1'b1, 1'b1, 12'hAAA, 1'b1);
    applyStimulus(3,  16'd4, 16'd0, 16'h0005, 10'd3,    10'd4,  1'b1, 1'b1, 12'h777, 1'b1);
    applyStimulus(4,  16'd4, 16'd0, 16'h0000, 10'd3,    10'd6,  1'b1, 1'b1, 12'h777, 1'b1);
    applyStimulus(5,  16'd4, 16'd0, 16'h0003, 10'd2,    10'd2,  1'b1, 1'b1, 12'h5B0, 1'b1);
    applyStimulus(6,  16'd0, 16'd3, 16'h0000, 10'd33,   10'd2,  1'b1, 1'b1, 12'h5B0, 1'b1);
    applyStimulus(7,  16'd4, 16'd0, 16'hFFFF, 10'd3,    10'd4,  1'b1, 1'b1, 12'hAAA, 1'b1);
    applyStimulus(8,  16'd4, 16'd0, 16'h8000, 10'd3,    10'd4,  1'b1, 1'b1, 12'h777, 1'b1);
    applyStimulus(9,  16'd4, 16'd0, 16'h0005, 10'd3,    10'd19, 1'b1, 1'b1, 12'hAAA, 1'b1);
    applyStimulus(10, 16'd4, 16'd0, 16'h0005, 10'd3,    10'd20, 1'b1, 1'b1, 12'h5B0, 1'b1);
    applyStimulus(11, 16'd4, 16'd0, 16'h0005, 10'd3,    10'd2,  1'b0, 1'b1, 12'h000, 1'b1);
    applyStimulus(12, 16'd4, 16'd0, 16'h0005, 10'd3,    10'd2,  1'b1, 1'b0, 12'h000, 1'b1);
    applyStimulus(13, 16'd4, 16'd0, 16'h0005, 10'd1019, 10'd2,  1'b1, 1'b1, 12'hAAA, 1'b1);
    idle(5);

    anim_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      frame_tick = 1'b1;
      idle(1);
      frame_tick = 1'b0;
      idle(1);
    end
    applyStimulus(20, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'hAAA, 1'b1);
    frame_tick = 1'b1;
    applyStimulus(21, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'hAAA, 1'b1);
    frame_tick = 1'b0;
    applyStimulus(22, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'h000, 1'b1);
    anim_en = 1'b0;
    applyStimulus(23, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'h777, 1'b1);
    anim_en = 1'b1;
    applyStimulus(24, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'h000, 1'b1);
    anim_en = 1'b0;
    idle(5);

    // Write lands on the same edge as pixel 30's palette read.
    applyStimulus(30, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'h777, 1'b1);
    applyStimulus(31, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'hF00, 1'b1);
    pal_wr_en   = 1'b1;
    pal_wr_idx  = 2'd2;
    pal_wr_data = 12'hF00;
    applyStimulus(32, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'hF00, 1'b1);
    pal_wr_en = 1'b0;
    applyStimulus(33, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd2, 1'b1, 1'b1, 12'hAAA, 1'b1);
    idle(5);

    anim_en = 1'b1;
    frame_tick = 1'b1;
    idle(1);
    frame_tick = 1'b0;
    anim_en = 1'b0;
    applyStimulus(40, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'h000, 1'b0);
    applyStimulus(41, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'h000, 1'b0);
    sys_rst_n = 1'b0;
    applyStimulus(42, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'h000, 1'b0);
    checkOutput("midreset_rgb_valid", 42, int'(rgb_valid), 0);
    checkOutput("midreset_rgb", 42, int'(rgb), 0);
    sys_rst_n = 1'b1;
    idle(5);
    applyStimulus(43, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'h777, 1'b1);
    anim_en = 1'b1;
    applyStimulus(44, 16'd4, 16'd0, 16'h0005, 10'd3, 10'd4, 1'b1, 1'b1, 12'h777, 1'b1);
    anim_en = 1'b0;
    idle(1);

    for (int i = 0; i < 100 && expQ.size() != 0; i++) begin
      @(posedge sys_clk);
      #1;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: got %0d pixels still pending, expected 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
